// File: rtl/branch_pkg.sv
// Shared branch-unit types: branch-type encodings, the deferred-branch slot
// and the redirect-address helper.
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JMP  = 3'd7;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        predictTaken;
  } br_slot_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic [31:0] target,
                                          input logic        taken);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_stats.sv
// Resolved-branch and misprediction counters; hold when disabled, wrap freely.
module branch_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       br_inc,
  input  logic [1:0]       miss_inc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (en) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(br_inc);
      miss_cnt_d   = miss_cnt_q + CNT_W'(miss_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: EX/MEM misprediction detection, redirect, flush,
// registered predictor update and statistics.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       ex_branchType,
  input  logic             ex_predictTaken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_condReady,
  input  logic             ex_taken,
  input  logic             mem_taken,
  output logic             correctAtEX,
  output logic             correctAtMEM,
  output logic [31:0]      redirect_pc,
  output logic             flush_idex,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_addr,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  br_slot_t         slot_q, slot_d;
  logic             squash_q, squash_d;
  logic             upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0] upd_addr_q, upd_addr_d;
  logic             upd_taken_q, upd_taken_d;

  logic active, mem_res, mem_mis;
  logic is_jmp, ex_ready, ex_actual, ex_live, ex_res, ex_mis, ex_defer;
  logic [1:0] br_inc, miss_inc;

  always_comb begin
    // A reset cycle behaves like a frozen cycle so a pending slot never fires.
    active    = !stall && !rst;
    mem_res   = slot_q.valid && active;
    mem_mis   = mem_res && (mem_taken != slot_q.predictTaken);

    is_jmp    = (ex_branchType == BR_JMP);
    ex_ready  = is_jmp || ex_condReady;
    ex_actual = is_jmp || ex_taken;
    ex_live   = (ex_branchType != BR_NONE) && active && !squash_q && !mem_mis;
    ex_res    = ex_live && ex_ready;
    ex_mis    = ex_res && (ex_actual != ex_predictTaken);
    ex_defer  = ex_live && !ex_ready;

    correctAtEX  = ex_mis;
    correctAtMEM = mem_mis;
    flush_idex   = ex_mis || mem_mis;
    redirect_pc  = '0;
    if (mem_mis)
      redirect_pc = next_pc(slot_q.pc, slot_q.target, mem_taken);
    else if (ex_mis)
      redirect_pc = next_pc(ex_pc, ex_target, ex_actual);

    br_inc   = {1'b0, mem_res} + {1'b0, ex_res};
    miss_inc = {1'b0, mem_mis} + {1'b0, ex_mis};

    slot_d      = slot_q;
    squash_d    = squash_q;
    upd_valid_d = upd_valid_q;
    upd_addr_d  = upd_addr_q;
    upd_taken_d = upd_taken_q;
    if (!stall) begin
      slot_d.valid = ex_defer;
      if (ex_defer) begin
        slot_d.pc           = ex_pc;
        slot_d.target       = ex_target;
        slot_d.predictTaken = ex_predictTaken;
      end
      squash_d    = ex_mis || mem_mis;
      upd_valid_d = mem_res || ex_res;
      // The MEM branch is older, so it owns the update port when both resolve.
      if (mem_res) begin
        upd_addr_d  = slot_q.pc[IDX_W+1:2];
        upd_taken_d = mem_taken;
      end else if (ex_res) begin
        upd_addr_d  = ex_pc[IDX_W+1:2];
        upd_taken_d = ex_actual;
      end
    end
  end

  // ---- resolution / update register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      squash_q    <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      squash_q    <= squash_d;
      upd_valid_q <= upd_valid_d;
      upd_addr_q  <= upd_addr_d;
      upd_taken_q <= upd_taken_d;
    end
  end

  assign upd_valid = upd_valid_q && !stall;
  assign upd_addr  = upd_addr_q;
  assign upd_taken = upd_taken_q;

  branch_stats #(.CNT_W(CNT_W)) u_stats (
    .clk        (clk),
    .rst        (rst),
    .en         (!stall),
    .br_inc     (br_inc),
    .miss_inc   (miss_inc),
    .branch_cnt (branch_cnt),
    .miss_cnt   (miss_cnt)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed plan cases plus random
// traffic against a queue-based behavioural model.
module tb_branch_resolve;

  localparam int IDX_W = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, stall;
  logic [2:0]       ex_branchType;
  logic             ex_predictTaken, ex_condReady, ex_taken, mem_taken;
  logic [31:0]      ex_pc, ex_target;
  logic             correctAtEX, correctAtMEM, flush_idex, upd_valid, upd_taken;
  logic [31:0]      redirect_pc;
  logic [IDX_W-1:0] upd_addr;
  logic [CNT_W-1:0] branch_cnt, miss_cnt;

  always #5 clk = ~clk;

  branch_resolve #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_branchType(ex_branchType), .ex_predictTaken(ex_predictTaken),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_condReady(ex_condReady),
    .ex_taken(ex_taken), .mem_taken(mem_taken),
    .correctAtEX(correctAtEX), .correctAtMEM(correctAtMEM),
    .redirect_pc(redirect_pc), .flush_idex(flush_idex),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Behavioural model: deferred branches waiting for MEM, pending update, counts.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          pred;
  } pend_t;

  pend_t            pq[$];
  bit               sq;
  bit               eu_v, eu_t;
  logic [IDX_W-1:0] eu_addr;
  logic [CNT_W-1:0] bc, mc;

  logic        obs_cex, obs_cmem, obs_flush;
  logic [31:0] obs_redir;

  task automatic drive(input logic [2:0] ty, input bit pred, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit rdy, input bit tk,
                       input bit mt, input bit st, input bit rs);
    ex_branchType = ty; ex_predictTaken = pred; ex_pc = pc; ex_target = tgt;
    ex_condReady = rdy; ex_taken = tk; mem_taken = mt; stall = st; rst = rs;
  endtask

  task automatic idle_inputs();
    drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  // One clock: check outputs for the driven inputs, then advance the model.
  task automatic step();
    bit act, m_res, m_mis, jmp, rdy, dir, ex_ok, e_res, e_mis, e_def;
    logic [31:0] rd;
    pend_t head;
    head  = '{pc: 32'h0, tgt: 32'h0, pred: 1'b0};
    if (pq.size() > 0) head = pq[0];
    act   = !stall && !rst;
    m_res = act && (pq.size() > 0);
    m_mis = m_res && (mem_taken != head.pred);
    jmp   = (ex_branchType == 3'd7);
    rdy   = jmp || ex_condReady;
    dir   = jmp || ex_taken;
    ex_ok = (ex_branchType != 3'd0) && act && !sq && !m_mis;
    e_res = ex_ok && rdy;
    e_mis = e_res && (dir != ex_predictTaken);
    e_def = ex_ok && !rdy;
    if (m_mis)      rd = mem_taken ? head.tgt : head.pc + 32'd4;
    else if (e_mis) rd = dir ? ex_target : ex_pc + 32'd4;
    else            rd = 32'h0;

    #1;
    obs_cex = correctAtEX; obs_cmem = correctAtMEM;
    obs_flush = flush_idex; obs_redir = redirect_pc;
    chk("correctAtEX", obs_cex, e_mis);
    chk("correctAtMEM", obs_cmem, m_mis);
    chk("flush_idex", obs_flush, m_mis || e_mis);
    chk("redirect_pc", obs_redir, rd);
    chk("upd_valid", upd_valid, eu_v && !stall);
    if (eu_v) begin
      chk("upd_addr", upd_addr, eu_addr);
      chk("upd_taken", upd_taken, eu_t);
    end
    chk("branch_cnt", branch_cnt, bc);
    chk("miss_cnt", miss_cnt, mc);

    @(posedge clk);
    if (rst) begin
      pq.delete(); sq = 0; eu_v = 0; eu_t = 0; eu_addr = '0; bc = '0; mc = '0;
    end else if (!stall) begin
      if (m_res) begin
        eu_v = 1; eu_addr = head.pc[IDX_W+1:2]; eu_t = mem_taken;
        void'(pq.pop_front());
      end else if (e_res) begin
        eu_v = 1; eu_addr = ex_pc[IDX_W+1:2]; eu_t = dir;
      end else begin
        eu_v = 0;
      end
      if (e_def) pq.push_back('{pc: ex_pc, tgt: ex_target, pred: ex_predictTaken});
      sq = m_mis || e_mis;
      bc = bc + CNT_W'(m_res) + CNT_W'(e_res);
      mc = mc + CNT_W'(m_mis) + CNT_W'(e_mis);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
  endtask

  task automatic idle_step();
    drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  logic [CNT_W-1:0] bc_before;

  initial begin
    drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sq = 0; eu_v = 0; eu_t = 0; eu_addr = '0; bc = '0; mc = '0;
    do_reset();
    idle_inputs();
    chk("rst_upd_valid", upd_valid, 1'b0);
    chk("rst_upd_addr", upd_addr, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    // EX misprediction
    drive(3'd1, 1'b1, 32'h100, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t1_cex", obs_cex, 1'b1);
    chk("t1_redirect", obs_redir, 32'h104);
    chk("t1_flush", obs_flush, 1'b1);
    idle_inputs();
    chk("t1_upd_valid", upd_valid, 1'b1);
    chk("t1_upd_addr", upd_addr, 0);
    chk("t1_upd_taken", upd_taken, 1'b0);
    chk("t1_miss_cnt", miss_cnt, 1);
    idle_step();

    // EX hit on an unconditional jump (condReady deliberately 0)
    do_reset();
    drive(3'd7, 1'b1, 32'h200, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t2_cex", obs_cex, 1'b0);
    chk("t2_flush", obs_flush, 1'b0);
    idle_inputs();
    chk("t2_upd_taken", upd_taken, 1'b1);
    chk("t2_branch_cnt", branch_cnt, 1);
    chk("t2_miss_cnt", miss_cnt, 0);
    idle_step();

    // Deferred branch resolved in MEM
    drive(3'd2, 1'b0, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_defer_no_cex", obs_cex, 1'b0);
    drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("t3_cmem", obs_cmem, 1'b1);
    chk("t3_redirect", obs_redir, 32'h80);
    idle_inputs();
    chk("t3_upd_addr", upd_addr, 6'h10);
    idle_step();

    // MEM correction collides with a mispredicted EX branch
    drive(3'd3, 1'b0, 32'h60, 32'h90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bc_before = bc;
    drive(3'd1, 1'b1, 32'h300, 32'h700, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("t4_cmem", obs_cmem, 1'b1);
    chk("t4_cex", obs_cex, 1'b0);
    idle_inputs();
    chk("t4_branch_delta", branch_cnt, CNT_W'(bc_before + 1));
    idle_step();

    // Stall with a slot pending for three cycles
    drive(3'd4, 1'b1, 32'h84, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk("t5_stall_cmem", obs_cmem, 1'b0);
      chk("t5_stall_flush", obs_flush, 1'b0);
    end
    drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t5_resolve_cmem", obs_cmem, 1'b1);
    chk("t5_redirect", obs_redir, 32'h88);
    idle_step();

    // Reset while a deferred branch is pending
    drive(3'd5, 1'b0, 32'h44, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk("t6_rst_cmem", obs_cmem, 1'b0);
    idle_step();
    chk("t6_rst_branch_cnt", branch_cnt, 0);

    // Counter wrap: 255 misses, then one more
    for (int i = 0; i < 255; i++) begin
      drive(3'd1, 1'b1, 32'h10 + 32'(i * 4), 32'h800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      idle_step();
    end
    idle_inputs();
    chk("t6_pre_wrap_br", branch_cnt, 8'hFF);
    chk("t6_pre_wrap_miss", miss_cnt, 8'hFF);
    drive(3'd6, 1'b0, 32'h1000, 32'h1800, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle_inputs();
    chk("t6_wrap_br", branch_cnt, 0);
    chk("t6_wrap_miss", miss_cnt, 0);
    idle_step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [2:0] ty;
      r = $urandom_range(0, 9);
      if (r < 4)      ty = 3'd0;
      else if (r < 6) ty = 3'd7;
      else            ty = 3'($urandom_range(1, 6));
      drive(ty, 1'($urandom), {$urandom_range(0, 32'hFFFF), 2'b00} , $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
            $urandom_range(0, 6) == 0, $urandom_range(0, 60) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolves predicted branches and is the producing end of the IBranchCorrect protocol. The ID-stage predictor consumes that protocol.
- Compares each branch's predicted direction with its actual outcome. Actual outcome comes from EX, or from MEM when the condition depends on a late load operand.
- On a misprediction it asserts correctAtEX/correctAtMEM, a redirect PC and flush strobes.
- Also issues a registered outcome-update to the predictor and keeps branch/miss statistics.

Parameters:
- IDX_W, 6, predictor table index width; upd_addr = pc[IDX_W+1:2].
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- stall  in  1  pipeline freeze; holds all state.
- ex_branchType  in  3  branch type of the EX instruction; 0 = not a branch.
- ex_predictTaken  in  1  prediction made in ID, carried down the pipeline.
- ex_pc  in  32  PC of the EX branch.
- ex_target  in  32  computed taken-target.
- ex_condReady  in  1  condition is resolvable in EX.
- ex_taken  in  1  actual direction; valid when ex_condReady = 1.
- mem_taken  in  1  actual direction for the deferred branch, sampled in MEM.
- correctAtEX  out  1  misprediction resolved in EX (IBranchCorrect).
- correctAtMEM  out  1  misprediction resolved in MEM (IBranchCorrect).
- redirect_pc  out  32  fetch restart address.
- flush_idex  out  1  squash IF/ID and ID/EX.
- upd_valid  out  1  registered outcome update.
- upd_addr  out  IDX_W  update index.
- upd_taken  out  1  actual direction.
- branch_cnt  out  CNT_W  resolved branches.
- miss_cnt  out  CNT_W  mispredicted branches.

Behaviour:
Direction rules
- Effective actual direction = 1 for BR_JMP, regardless of ex_taken/mem_taken.
- BR_JMP is always resolvable in EX; ex_condReady is ignored for it.

EX resolution (combinational)
- EX resolves when ex_branchType != BR_NONE, ex_condReady = 1, stall = 0, and no squash is in force.
- mis = actual != ex_predictTaken.
- correctAtEX = mis.
- redirect_pc = actual ? ex_target : ex_pc + 4 (mod 2^32).

Deferral to MEM
- If ex_branchType != BR_NONE and ex_condReady = 0 (not BR_JMP), capture a pending slot at the clock edge.
- Slot contents: valid, pc, target, predictTaken.
- The next cycle the slot resolves against mem_taken:
  - correctAtMEM = slot.valid & (mem_taken != slot.predictTaken).
  - redirect_pc from the slot, using the same rule as EX.
- The slot is cleared after one unstalled cycle.

Simultaneous events
- MEM correction and a live EX branch in the same cycle: MEM is older and wins.
  - correctAtEX is forced to 0.
  - The EX branch is squashed: no update, no counting, no slot capture.
- Any correction squashes the EX instruction the following cycle, so a MEM correction can never be followed by a stale slot.

Flush and stall
- flush_idex = correctAtEX | correctAtMEM.
- stall = 1:
  - every output strobe (correctAtEX, correctAtMEM, flush_idex, upd_valid) = 0;
  - the slot, counters and update register hold.
- redirect_pc = 0 when no correction.

Update port
- Registered one cycle after any unsquashed resolution (EX or MEM, hit or miss).
- upd_valid = 1, upd_addr = pc[IDX_W+1:2], upd_taken = actual.
- At most one resolution per cycle, because MEM priority squashes EX.

Counters
- branch_cnt += 1 per resolution.
- miss_cnt += 1 per misprediction.
- Both wrap modulo 2^CNT_W.

Reset
- Clears the slot, upd_valid, upd_addr, upd_taken, branch_cnt and miss_cnt.
- Combinational outputs are 0 while the slot is invalid and no EX branch is present.
- Reset mid-deferral discards the pending branch: no correction and no count.

Decomposition:
- Package branch_pkg holds:
  - branchType constants: BR_NONE = 3'd0, BR_JMP = 3'd7, 1–6 conditional (BEQ…BGEU);
  - typedef struct br_slot_t {valid, pc, target, predictTaken};
  - function next_pc(pc, target, taken).
- Optional sub-module branch_stats: the two counters with hold/wrap behaviour.

Test Plan:
1. EX miss: branchType = 1, predictTaken = 1, condReady = 1, ex_taken = 0, pc = 0x100.
   -> correctAtEX = 1, redirect_pc = 0x104, flush = 1.
   -> next cycle upd_valid = 1, upd_addr = 0, upd_taken = 0; miss_cnt = 1.
2. EX hit: BR_JMP, predictTaken = 1, target = 0x2000.
   -> no correct/flush; upd_taken = 1; branch_cnt = 1, miss_cnt = 0.
3. Deferred: condReady = 0, predictTaken = 0, pc = 0x40, target = 0x80; next cycle mem_taken = 1.
   -> correctAtMEM = 1, redirect_pc = 0x80, upd_addr = 0x10.
4. Collision: deferred miss in MEM while a new mispredicted EX branch is present.
   -> only correctAtMEM; correctAtEX = 0; branch_cnt increments by 1.
5. Stall with slot pending for 3 cycles.
   -> no strobes during the stall; resolves on the first unstalled cycle.
6. rst asserted with slot valid; counters preloaded to 2^CNT_W − 1 before a miss.
   -> the reset case yields no correctAtMEM; in the wrap case both branch_cnt and miss_cnt wrap to 0.
